systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencer for the N×N systolic multiply array: on `start` it clears the PE accumulators, reads A/B operand slices from the operand buffers, applies the diagonal skew, drives the array's west and north edges with zero fill, and pulses `done` once every PE holds its final dot product. It sits between the operand buffers and the PE grid, and is the only block that drives the grid's edge inputs and accumulator clear.

## Interface
- `N`, 4, array dimension (rows = columns = inner dimension K); N ≥ 2
- `DW`, 8, operand width; must match PE input width
- `AW`, `$clog2(N)`, operand buffer slice address width
- `clk` in 1 — clock, rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `start` in 1 — single-cycle run request; honoured only in IDLE
- `busy` out 1 — high from the cycle after an accepted `start` through the `done` cycle
- `done` out 1 — one-cycle pulse; all PE results final and stable
- `arr_clr` out 1 — one-cycle accumulator clear, ORed into the PE reset by the top level
- `rd_en` out 1 — operand buffer read strobe
- `rd_addr` out AW — slice index k
- `a_slice` in N*DW — A[0..N-1][k]; lane i = bits [i*DW +: DW]; valid 1 cycle after `rd_en`
- `b_slice` in N*DW — B[k][0..N-1]; same lane and latency rules
- `west_out` out N*DW — lane i drives the west input of row i
- `north_out` out N*DW — lane j drives the north input of column j
- `perf_cycles` out 32 — present only with `SYSTOLIC_SEQ_CTRL_PERF_EN`

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: `start` = 1 → CLEAR. Otherwise stay.
- CLEAR: one cycle, `arr_clr` = 1 → FEED.
- FEED: N cycles; `rd_en` = 1, `rd_addr` = 0..N-1 in order; after k = N-1 → DRAIN.
- DRAIN: continues until the drain counter reaches its terminal value (see Timing) → DONE.
- DONE: one cycle, `done` = 1 → IDLE.
- Skew: `a_slice` lane i is delayed i extra cycles before reaching `west_out` lane i. `b_slice` lane j is delayed j extra cycles before reaching `north_out` lane j. Each lane carries 0 in every cycle that has no valid slice, so stray PE products are zero.
- `start` outside IDLE, including the DONE cycle, is ignored; no queuing.
- Async `rst` mid-run: FSM → IDLE, skew registers zeroed, all outputs to reset values. PE contents are undefined until the next run's CLEAR.
- Reset values: `busy` 0, `done` 0, `arr_clr` 0, `rd_en` 0, `rd_addr` 0, `west_out` 0, `north_out` 0, `perf_cycles` 0.
- No arithmetic beyond counters. Counters are sized to `$clog2(3N)` and never wrap within a run.

## Timing
- `start` sampled at edge of cycle t.
- t+1: CLEAR, `busy` rises.
- t+2..t+N+1: FEED reads.
- Slice k is on `a_slice`/`b_slice` at t+3+k.
- Edge outputs are registered. Define f = cycle − (t+3).
  - `west_out[i]` = A[i][f−i] when 0 ≤ f−i < N, else 0.
  - `north_out[j]` = B[f−j][j] under the same condition.
- The last nonzero operand reaches PE(N-1,N-1) at f = 3N−3. That PE accumulates it at the end of that cycle.
- `done` is at cycle t+3N+1 (N=4: t+13). `busy` falls at t+3N+2. Total latency start→done is 3N+1 cycles.
- Back-to-back runs: the earliest next accepted `start` is at t+3N+2.

## Configuration
- `SYSTOLIC_SEQ_CTRL_PERF_EN` defined:
  - `perf_cycles` counts `busy` cycles of the current run.
  - It clears on accepted `start`, holds after `done`, and saturates at 2^32−1.
  - Expected value after a run is 3N+1.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- `systolic_pkg`: FSM state enum, default `N`/`DW`, and the latency constants FEED_CYC = N and DONE_LAT = 3N+1.
- Sub-module `systolic_skew_buf`:
  - Parameterised lane count and width.
  - Per-lane shift depth i, zero-fill on invalid input.
  - Instantiated twice: A→west and B→north.

## Test plan
- N=4, A = I, B[k][j] = 4k+j+1 → `done` at t+13, and every PE(i,j) result = B[i][j].
- A and B all 255 → every result = 4·255·255 = 260100 (checks 16-bit+ PE width at top level). `west_out[3]` nonzero only for f = 3..6.
- Second `start` pulsed at t+5 and at the DONE cycle → ignored; exactly one `done`. A start at t+14 is accepted.
- `rst` asserted at t+7 → all outputs 0 immediately. A new run then yields correct results (arr_clr observed).
- Two consecutive runs with different A/B → second run results are independent of the first (clear verified).
- With `SYSTOLIC_SEQ_CTRL_PERF_EN` → `perf_cycles` = 13 after `done`, and it holds while idle.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state type, defaults and latency constants for the systolic sequencer
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int DEF_N    = 4;
    localparam int DEF_DW   = 8;
    localparam int FEED_CYC = DEF_N;
    localparam int DONE_LAT = 3 * DEF_N + 1;

    function automatic int feed_cyc(input int n);
        return n;
    endfunction

    // start-to-done latency: clear, N feed cycles, skew + array traversal, done
    function automatic int done_lat(input int n);
        return 3 * n + 1;
    endfunction

endpackage

// File: rtl/systolic_skew_buf.sv
// rtl/systolic_skew_buf.sv - per-lane diagonal skew, lane i delayed i cycles, zero on invalid input
module systolic_skew_buf #(
    parameter int LANES = 4,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [LANES*W-1:0] din,
    output logic [LANES*W-1:0] dout
);

    logic [LANES*W-1:0] din_z;

    assign din_z       = vld ? din : '0;
    assign dout[W-1:0] = din_z[W-1:0];

    for (genvar i = 1; i < LANES; i++) begin : g_lane
        logic [W-1:0] sr [i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int d = 0; d < i; d++) sr[d] <= '0;
            end else begin
                sr[0] <= din_z[i*W +: W];
                for (int d = 1; d < i; d++) sr[d] <= sr[d-1];
            end
        end

        assign dout[i*W +: W] = sr[i-1];
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - systolic array sequencer (clear, feed, skew, drain, done); perf counter under SYSTOLIC_SEQ_CTRL_PERF_EN
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            arr_clr,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [N*DW-1:0] a_slice,
    input  logic [N*DW-1:0] b_slice,
    output logic [N*DW-1:0] west_out,
    output logic [N*DW-1:0] north_out
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);

    localparam int CW = $clog2(3 * N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(feed_cyc(N) - 1);
    // drain spans the rest of the latency after clear, feed and done
    localparam logic [CW-1:0] DRAIN_LAST = CW'(done_lat(N) - feed_cyc(N) - 3);

    seq_state_t    state, nxt;
    logic [CW-1:0] cnt;
    logic          rd_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rd_vld <= 1'b0;
        end else begin
            state  <= nxt;
            rd_vld <= rd_en;
            if (state != nxt)
                cnt <= '0;
            else if (state == ST_FEED || state == ST_DRAIN)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nxt     = state;
        busy    = (state != ST_IDLE);
        arr_clr = 1'b0;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE:  if (start) nxt = ST_CLEAR;
            ST_CLEAR: begin
                arr_clr = 1'b1;
                nxt     = ST_FEED;
            end
            ST_FEED: begin
                rd_en = 1'b1;
                if (cnt == FEED_LAST) nxt = ST_DRAIN;
            end
            ST_DRAIN: if (cnt == DRAIN_LAST) nxt = ST_DONE;
            ST_DONE: begin
                done = 1'b1;
                nxt  = ST_IDLE;
            end
            default:  nxt = ST_IDLE;
        endcase
    end

    assign rd_addr = rd_en ? cnt[AW-1:0] : '0;

    systolic_skew_buf #(.LANES(N), .W(DW)) u_skew_a (
        .clk  (clk),
        .rst  (rst),
        .vld  (rd_vld),
        .din  (a_slice),
        .dout (west_out)
    );

    systolic_skew_buf #(.LANES(N), .W(DW)) u_skew_b (
        .clk  (clk),
        .rst  (rst),
        .vld  (rd_vld),
        .din  (b_slice),
        .dout (north_out)
    );

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_cycles <= '0;
        else if (state == ST_IDLE && start)
            perf_cycles <= '0;
        else if (busy && perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized self-checking bench with an operand buffer and PE grid model
module tb_systolic_seq_ctrl;
    import systolic_pkg::*;

    localparam int N   = DEF_N;
    localparam int DW  = DEF_DW;
    localparam int AW  = $clog2(N);
    localparam int LAT = DONE_LAT;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, arr_clr, rd_en;
    logic [AW-1:0]   rd_addr;
    logic [N*DW-1:0] a_slice, b_slice, west_out, north_out;
    logic [31:0]     perf_cycles;

    systolic_seq_ctrl #(.N(N), .DW(DW)) dut (
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .arr_clr   (arr_clr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .a_slice   (a_slice),
        .b_slice   (b_slice),
        .west_out  (west_out),
        .north_out (north_out)
    );

`ifndef SYSTOLIC_SEQ_CTRL_PERF_EN
    assign perf_cycles = '0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int a_m [N][N];
    int b_m [N][N];
    int acc [N][N];
    int pa  [N][N];
    int pb  [N][N];
    int run_t = -1;
    int cyc = 0;
    int dcount = 0;
    logic          rd_prev;
    logic [AW-1:0] addr_prev;
    longint        perf_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int edge_exp(input bit is_a, input int c, input int lane);
        int f;
        if (run_t < 0) return 0;
        f = c - run_t - 3 - lane;
        if (f < 0 || f >= N) return 0;
        return is_a ? a_m[lane][f] : b_m[f][lane];
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".arr_clr"}, 64'(arr_clr), 64'd0);
        chk({tag, ".rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, ".rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, ".west"}, 64'(west_out), 64'd0);
        chk({tag, ".north"}, 64'(north_out), 64'd0);
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
        chk({tag, ".perf"}, 64'(perf_cycles), 64'd0);
`endif
    endtask

    // reference PE grid: each PE forwards west->east, north->south and accumulates the product
    task automatic grid_step(input logic clr);
        int na [N][N];
        int nb [N][N];
        int win, nin;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                win = (j == 0) ? int'(west_out[i*DW +: DW]) : pa[i][j-1];
                nin = (i == 0) ? int'(north_out[j*DW +: DW]) : pb[i-1][j];
                if (clr) begin
                    acc[i][j] = 0;
                    na[i][j]  = 0;
                    nb[i][j]  = 0;
                end else begin
                    acc[i][j] += win * nin;
                    na[i][j]  = win;
                    nb[i][j]  = nin;
                end
            end
        end
        pa = na;
        pb = nb;
    endtask

    task automatic step(input bit sreq);
        logic [N*DW-1:0] av, bv;
        bit act, idle, busy_e, rde;
        int sum;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rd_prev) begin
                av[i*DW +: DW] = DW'(a_m[i][addr_prev]);
                bv[i*DW +: DW] = DW'(b_m[addr_prev][i]);
            end else begin
                av[i*DW +: DW] = DW'($urandom);
                bv[i*DW +: DW] = DW'($urandom);
            end
        end
        a_slice = av;
        b_slice = bv;
        start   = sreq;
        #1;
        act    = (run_t >= 0);
        busy_e = act && cyc >= run_t + 1 && cyc <= run_t + LAT;
        rde    = act && cyc >= run_t + 2 && cyc <= run_t + N + 1;
        idle   = !act || cyc >= run_t + LAT + 1;
        chk("busy", 64'(busy), 64'(busy_e));
        chk("done", 64'(done), 64'(act && cyc == run_t + LAT));
        chk("arr_clr", 64'(arr_clr), 64'(act && cyc == run_t + 1));
        chk("rd_en", 64'(rd_en), 64'(rde));
        chk("rd_addr", 64'(rd_addr), 64'(rde ? cyc - run_t - 2 : 0));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("west[%0d]", i), 64'(west_out[i*DW +: DW]), 64'(edge_exp(1'b1, cyc, i)));
            chk($sformatf("north[%0d]", i), 64'(north_out[i*DW +: DW]), 64'(edge_exp(1'b0, cyc, i)));
        end
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
        chk("perf", 64'(perf_cycles), 64'(perf_exp));
`endif
        if (done) dcount++;
        if (act && cyc == run_t + LAT) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    sum = 0;
                    for (int k = 0; k < N; k++) sum += a_m[i][k] * b_m[k][j];
                    chk($sformatf("pe(%0d,%0d)", i, j), 64'(acc[i][j]), 64'(sum));
                end
            end
        end
        grid_step(arr_clr);
        if (sreq && idle) begin
            perf_exp = 0;
            run_t    = cyc;
        end else if (busy_e && perf_exp < 64'hFFFF_FFFF) begin
            perf_exp++;
        end
        rd_prev   = rd_en;
        addr_prev = rd_addr;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        #1;
        rst      = 1'b0;
        run_t    = -1;
        rd_prev  = 1'b0;
        perf_exp = 0;
    endtask

    task automatic run_seq(input int ncyc, input logic [63:0] smask, input int rst_at);
        for (int i = 0; i < ncyc; i++) begin
            if (i == rst_at) async_reset();
            step(smask[i]);
        end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = int'($urandom_range(0, 255));
                b_m[i][j] = int'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a_slice   = '0;
        b_slice   = '0;
        rd_prev   = 1'b0;
        addr_prev = '0;
        perf_exp  = 0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = (i == j) ? 1 : 0;
                b_m[i][j] = N * i + j + 1;
            end
        end
        run_seq(20, 64'h1, -1);

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = 255;
                b_m[i][j] = 255;
            end
        end
        run_seq(20, 64'h1, -1);

        rand_mats();
        dcount = 0;
        run_seq(34, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 13) | (64'd1 << 14), -1);
        chk("done_count", 64'(dcount), 64'd2);

        rand_mats();
        run_seq(30, (64'd1 << 0) | (64'd1 << 9), 7);

        for (int r = 0; r < 4; r++) begin
            rand_mats();
            run_seq(LAT + 1, 64'h1, -1);
        end
        run_seq(6, 64'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
